// File: rtl/fifo_ram_pkg.sv
// rtl/fifo_ram_pkg.sv - shared sizes and grant encoding for the RAM-backed FIFO
package fifo_ram_pkg;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 2 ** ADDR_W;

   // occupancy value meaning "full", sized like the count register
   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_PUSH,
      GNT_POP
   } gnt_e;
endpackage

// File: rtl/fifo_ram_ctrl_if.sv
// rtl/fifo_ram_ctrl_if.sv - push/pop requester bundle for the FIFO controller
interface fifo_ram_ctrl_if;
   logic                                  push;
   logic [fifo_ram_pkg::DATA_W-1:0]       push_data;
   logic                                  push_ready;
   logic                                  pop;
   logic                                  pop_ready;
   logic                                  pop_valid;
   logic [fifo_ram_pkg::DATA_W-1:0]       pop_data;
   logic                                  full;
   logic                                  empty;
   logic [fifo_ram_pkg::ADDR_W:0]         count;

   modport master (
      output push, push_data, pop,
      input  push_ready, pop_ready, pop_valid, pop_data, full, empty, count
   );

   modport slave (
      input  push, push_data, pop,
      output push_ready, pop_ready, pop_valid, pop_data, full, empty, count
   );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, bit 0 = push, bit 1 = pop
module rr_arb2 (
   input  logic       ck,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   // prio_q high means the pop side wins the next conflict
   logic prio_q;
   logic prio_d;

   // grant selection; priority only moves to the loser of a real conflict
   always_comb begin
      gnt    = 2'b00;
      prio_d = prio_q;
      case (req)
         2'b01: gnt = 2'b01;
         2'b10: gnt = 2'b10;
         2'b11: begin
            gnt    = prio_q ? 2'b10 : 2'b01;
            prio_d = ~prio_q;
         end
         default: gnt = 2'b00;
      endcase
   end

   // priority register, starts out favouring pop
   always_ff @(posedge ck or posedge rst) begin
      if (rst) prio_q <= 1'b1;
      else     prio_q <= prio_d;
   end
endmodule

// File: rtl/fifo_ram_ctrl.sv
// rtl/fifo_ram_ctrl.sv - FIFO controller driving a single-port synchronous RAM
module fifo_ram_ctrl
   import fifo_ram_pkg::*;
(
   input  logic              ck,
   input  logic              rst,
   fifo_ram_ctrl_if.slave    bus,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              pop_valid_q, pop_valid_d;

   logic              full_w;
   logic              empty_w;
   logic [1:0]        req_w;
   logic [1:0]        gnt_w;
   gnt_e              grant;

   assign full_w  = (count_q == FULL_COUNT);
   assign empty_w = (count_q == '0);

   // a push into a full FIFO or a pop from an empty one never competes for the port
   assign req_w = {bus.pop && !empty_w, bus.push && !full_w};

   rr_arb2 u_arb (
      .ck  (ck),
      .rst (rst),
      .req (req_w),
      .gnt (gnt_w)
   );

   // one-hot arbiter grant to the named grant value
   always_comb begin
      grant = GNT_NONE;
      if (gnt_w[0])      grant = GNT_PUSH;
      else if (gnt_w[1]) grant = GNT_POP;
   end

   // pointer, occupancy and read-valid advance for the granted operation
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      pop_valid_d = 1'b0;
      case (grant)
         GNT_PUSH: begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
         end
         GNT_POP: begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            count_d     = count_q - 1'b1;
            pop_valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   // RAM port drive and requester status; idle address/data just follow the write side
   always_comb begin
      ram_cs         = (grant != GNT_NONE);
      ram_we         = (grant == GNT_PUSH);
      ram_addr       = (grant == GNT_POP) ? rd_ptr_q : wr_ptr_q;
      ram_wdata      = bus.push_data;
      bus.push_ready = (grant == GNT_PUSH);
      bus.pop_ready  = (grant == GNT_POP);
      bus.pop_valid  = pop_valid_q;
      bus.pop_data   = ram_rdata;
      bus.full       = full_w;
      bus.empty      = empty_w;
      bus.count      = count_q;
   end

   // state registers; reset drops any in-flight read and abandons RAM contents
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         pop_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pop_valid_q <= pop_valid_d;
      end
   end
endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// tb/tb_fifo_ram_ctrl.sv - scoreboard bench for fifo_ram_ctrl with a behavioural RAM
module tb_fifo_ram_ctrl;
   import fifo_ram_pkg::*;

   logic              ck = 1'b0;
   logic              rst = 1'b1;
   logic              ram_cs;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic [DATA_W-1:0] mem [DEPTH];

   int checks = 0;
   int errors = 0;

   // reference model: FIFO contents as a queue plus the arbitration rule
   logic [DATA_W-1:0] m_q[$];
   logic [DATA_W-1:0] exp_q[$];
   int                m_wr = 0;
   int                m_rd = 0;
   bit                prio_pop = 1'b1;

   fifo_ram_ctrl_if bus ();

   fifo_ram_ctrl dut (
      .ck        (ck),
      .rst       (rst),
      .bus       (bus),
      .ram_cs    (ram_cs),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   always #5 ck = ~ck;

   // 16x8 single-port synchronous RAM, one-cycle read latency
   always @(posedge ck) begin
      if (ram_cs) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every read-valid cycle must carry the oldest outstanding popped word
   always @(negedge ck) begin
      if (exp_q.size() > 0) begin
         chk("pop_valid", 32'(bus.pop_valid), 32'd1);
         chk("pop_data", 32'(bus.pop_data), 32'(exp_q.pop_front()));
      end else begin
         chk("pop_valid_idle", 32'(bus.pop_valid), 32'd0);
      end
   end

   task automatic cycle(input bit p, input logic [DATA_W-1:0] d, input bit q);
      int g;
      bit pr, pp;
      @(negedge ck);
      bus.push = p;
      bus.push_data = d;
      bus.pop = q;
      #1;
      pr = p && (m_q.size() < DEPTH);
      pp = q && (m_q.size() > 0);
      g = 0;
      if (pr && pp) begin
         g = prio_pop ? 2 : 1;
         prio_pop = !prio_pop;
      end else if (pr) g = 1;
      else if (pp) g = 2;
      chk("count", 32'(bus.count), 32'(m_q.size()));
      chk("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
      chk("empty", 32'(bus.empty), 32'(m_q.size() == 0));
      chk("push_ready", 32'(bus.push_ready), 32'(g == 1));
      chk("pop_ready", 32'(bus.pop_ready), 32'(g == 2));
      chk("ram_cs", 32'(ram_cs), 32'(g != 0));
      chk("ram_we", 32'(ram_we), 32'(g == 1));
      if (g == 1) begin
         chk("ram_addr_wr", 32'(ram_addr), 32'(m_wr));
         chk("ram_wdata", 32'(ram_wdata), 32'(d));
         m_q.push_back(d);
         m_wr = (m_wr + 1) % DEPTH;
      end
      if (g == 2) begin
         chk("ram_addr_rd", 32'(ram_addr), 32'(m_rd));
         exp_q.push_back(m_q.pop_front());
         m_rd = (m_rd + 1) % DEPTH;
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      exp_q.delete();
      m_wr = 0;
      m_rd = 0;
      prio_pop = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge ck);
      bus.push = 1'b0;
      bus.pop = 1'b0;
      rst = 1'b1;
      model_clear();
      @(negedge ck);
      #1;
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full", 32'(bus.full), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      bus.push = 1'b0;
      bus.push_data = '0;
      bus.pop = 1'b0;
      do_reset();

      // idle after reset
      for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0);

      // single push then pop
      cycle(1, 8'hA5, 0);
      cycle(0, 8'h00, 1);
      cycle(0, 8'h00, 0);

      // fill, overfill, drain back-to-back
      for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0);
      cycle(1, 8'hEE, 0);
      cycle(1, 8'hEF, 1);
      for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1);
      cycle(0, 8'h00, 1);

      // pointer wrap from a fresh reset
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1, 8'(8'h40 + i), 0);
      for (int i = 0; i < 10; i++) cycle(0, 8'h00, 1);
      for (int i = 0; i < 10; i++) cycle(1, 8'(8'h80 + i), 0);
      cycle(0, 8'h00, 0);

      // sustained conflict at count 5 alternates pop, push
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, 8'(8'h10 + i), 0);
      for (int i = 0; i < 8; i++) cycle(1, 8'(8'h20 + i), 1);
      cycle(0, 8'h00, 0);

      // reset right after an accepted pop drops the read
      cycle(0, 8'h00, 1);
      @(posedge ck);
      #2;
      rst = 1'b1;
      model_clear();
      #1;
      chk("midrst_pop_valid", 32'(bus.pop_valid), 32'd0);
      chk("midrst_count", 32'(bus.count), 32'd0);
      chk("midrst_empty", 32'(bus.empty), 32'd1);
      @(negedge ck);
      rst = 1'b0;
      cycle(1, 8'h77, 0);
      cycle(0, 8'h00, 1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50));
      end
      for (int i = 0; i < 20; i++) cycle(0, 8'h00, 1);
      cycle(0, 8'h00, 0);
      cycle(0, 8'h00, 0);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_ram_ctrl.md
Name: fifo_ram_ctrl

Overview:
Controller that turns the team's 16x8 single-port synchronous RAM into a FIFO. It owns the read and write pointers and the occupancy count. It arbitrates the single RAM port between a push requester and a pop requester, using round-robin on conflict. It drives the RAM's chip-select, write-enable, address and write-data, and returns read data with a one-cycle latency.

Parameters:
DATA_W, 8, data word width; matches RAM data_in/data_out.
ADDR_W, 4, RAM address width.
DEPTH, 16, FIFO capacity; must equal 2**ADDR_W.

Ports:
ck  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
push  input  1  push request.
push_data  input  DATA_W  word to store.
push_ready  output  1  push accepted this cycle when push && push_ready.
pop  input  1  pop request.
pop_ready  output  1  pop accepted this cycle when pop && pop_ready.
pop_valid  output  1  pop_data valid; one cycle after the accepted pop.
pop_data  output  DATA_W  popped word.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
count  output  ADDR_W+1  occupancy, 0..DEPTH.
ram_cs  output  1  to RAM chip_sel.
ram_we  output  1  to RAM write_enable.
ram_addr  output  ADDR_W  to RAM address.
ram_wdata  output  DATA_W  to RAM data_in.
ram_rdata  input  DATA_W  from RAM data_out.

Behaviour:
- Single clock ck. Asynchronous active-high reset rst.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, prio=POP. Consequently empty=1, full=0.
- Request qualification: push_req = push && !full; pop_req = pop && !empty.
- Grant, combinational, one per cycle:
  - Only push_req: grant PUSH.
  - Only pop_req: grant POP.
  - Both: grant the side held in prio.
  - After a conflict, prio flips to the loser.
  - prio does not change on non-conflict cycles.
- push_ready = (grant==PUSH); pop_ready = (grant==POP).
- Grant PUSH: ram_cs=1, ram_we=1, ram_addr=wr_ptr, ram_wdata=push_data. On the clock edge, wr_ptr+1 and count+1.
- Grant POP: ram_cs=1, ram_we=0, ram_addr=rd_ptr. On the clock edge, rd_ptr+1, count-1, and pop_valid<=1.
- No grant: ram_cs=0, ram_we=0. ram_addr and ram_wdata are don't-care; drive wr_ptr and push_data. pop_valid<=0.
- pop_data is wired directly to ram_rdata. It is meaningful only while pop_valid=1, in the cycle after grant POP.
- Pointers are ADDR_W bits and wrap naturally from 15 to 0. count never over- or underflows.
- count never changes by more than 1 per cycle, because push and pop are never both granted.
- Push while full: push_ready=0, no RAM access, no state change. This holds even if a pop is granted the same cycle; the push retries next cycle.
- Pop while empty: pop_ready=0, no access. A push in the same cycle is granted and does not flip prio.
- Back-to-back pops: pop_valid stays high on consecutive cycles, and each cycle carries the next word.
- Reset mid-operation:
  - State clears immediately.
  - A pending pop_valid is dropped.
  - RAM contents are left stale but unreachable.

Decomposition:
- Package fifo_ram_pkg holds DATA_W, ADDR_W, DEPTH, and the grant enum {GNT_NONE, GNT_PUSH, GNT_POP}.
- Sub-module rr_arb2: a two-requester round-robin arbiter. Inputs are req[1:0], ck, rst; output is a one-hot gnt[1:0]. It holds the prio flip-flop and resets to favour pop.
- Pointer, count and RAM-drive logic stay in fifo_ram_ctrl.

Test Plan:
- Reset then idle 3 cycles -> empty=1, full=0, count=0, pop_valid=0, ram_cs=0.
- Push 0xA5 then pop:
  - Push cycle: ram_we=1, ram_addr=0.
  - Pop cycle: ram_cs=1, ram_we=0, ram_addr=0.
  - Next cycle: pop_valid=1, pop_data=0xA5, count=0, empty=1.
- Push 0x00..0x0F (16 words) -> full=1, count=16. A 17th push gets push_ready=0 and count stays 16. Then 16 pops return 0x00..0x0F in order, with pop_valid high on 16 consecutive cycles.
- Wrap: push 10, pop 10, push 10 more -> ram_addr sequence 10..15,0..3, read order preserved, count=10.
- Hold push=1 and pop=1 with count=5 -> grants alternate POP, PUSH, POP, PUSH starting with POP after reset. count oscillates 4,5,4,5.
- Assert rst in the cycle after an accepted pop -> pop_valid=0 immediately; count=0, empty=1; the next push writes ram_addr=0.
